ball_motion_integrator: RTL

//  Per-frame ball kinematics stage. Holds ball velocity and sub-pixel position.

---
 rtl/ball_motion_integrator_if.sv | 43 ++++
 rtl/ball_motion_integrator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_integrator_if.sv
// ---------------------------------------------------------------------------
// ball_motion_integrator_if
//   Signal bundle between the frame/cue/collision logic and the ball motion
//   integrator. The driving side (frame timing, cue input, border_collision)
//   uses the master modport. The integrator uses the slave modport.
//
//   Signals (master -> slave):
//     startOfFrame        1-cycle pulse, once per video frame
//     shotValid           1-cycle pulse, cue strike request
//     shotVelX/Y    11s   strike velocity, sub-pixel units per frame
//     collisionOccurred   collision indication from border_collision
//     collVelX/Y    11s   corrected velocity from border_collision
//   Signals (slave -> master):
//     topLeftX/Y    11s   ball top-left position, integer pixels
//     ballVelX/Y    11s   current velocity, sub-pixel units per frame
//     moving              1 while the ball is in motion
// ---------------------------------------------------------------------------
interface ball_motion_integrator_if;
    logic                      startOfFrame;
    logic                      shotValid;
    logic signed [10:0]        shotVelX;
    logic signed [10:0]        shotVelY;
    logic                      collisionOccurred;
    logic signed [10:0]        collVelX;
    logic signed [10:0]        collVelY;
    logic signed [10:0]        topLeftX;
    logic signed [10:0]        topLeftY;
    logic signed [10:0]        ballVelX;
    logic signed [10:0]        ballVelY;
    logic                      moving;

    modport master (
        output startOfFrame, shotValid, shotVelX, shotVelY,
               collisionOccurred, collVelX, collVelY,
        input  topLeftX, topLeftY, ballVelX, ballVelY, moving
    );

    modport slave (
        input  startOfFrame, shotValid, shotVelX, shotVelY,
               collisionOccurred, collVelX, collVelY,
        output topLeftX, topLeftY, ballVelX, ballVelY, moving
    );
endinterface

// File: rtl/ball_motion_integrator.sv
// ---------------------------------------------------------------------------
// ball_motion_integrator
//   Per-frame ball kinematics. Holds the ball velocity and a sub-pixel
//   position. A cue shot starts motion. Collision-corrected velocities from
//   border_collision replace the velocity, at most once per frame. On every
//   frame pulse the position advances by the velocity. The integer top-left
//   position and the velocity feed the drawing and collision logic.
//
//   Ports:
//     clk      in   system clock
//     resetN   in   asynchronous, active-low reset
//     bus      ball_motion_integrator_if.slave
//              inputs:  startOfFrame, shotValid, shotVelX/Y,
//                       collisionOccurred, collVelX/Y
//              outputs: topLeftX/Y, ballVelX/Y, moving
//
//   Build option:
//     BALL_FRICTION_EN  when defined, every FRICTION_PERIOD frames each
//                       nonzero velocity component moves one unit toward
//                       zero, so the ball eventually comes to rest. When not
//                       defined there is no decay. The ball then stops only
//                       if a collision loads a zero velocity.
// ---------------------------------------------------------------------------
module ball_motion_integrator #(
    parameter int INIT_X          = 280,
    parameter int INIT_Y          = 185,
    parameter int FRAC_BITS       = 6,
    parameter int MAX_VEL         = 255,
    parameter int FRICTION_PERIOD = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    ball_motion_integrator_if.slave  bus
);

    localparam int DATA_W = 11;
    localparam int POS_W  = DATA_W + FRAC_BITS;

    localparam logic signed [POS_W-1:0]  POS_INIT_X = POS_W'(INIT_X * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0]  POS_INIT_Y = POS_W'(INIT_Y * (2 ** FRAC_BITS));
    localparam logic signed [DATA_W-1:0] TL_INIT_X  = DATA_W'(INIT_X);
    localparam logic signed [DATA_W-1:0] TL_INIT_Y  = DATA_W'(INIT_Y);
    localparam logic signed [DATA_W-1:0] VEL_MAX    = DATA_W'(MAX_VEL);
    localparam logic signed [DATA_W-1:0] VEL_MIN    = -VEL_MAX;
    localparam logic signed [DATA_W-1:0] VEL_ZERO   = '0;

`ifdef BALL_FRICTION_EN
    localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);
    localparam logic signed [DATA_W-1:0] VEL_ONE = DATA_W'(1);
`endif

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } state_t;

    // Saturate a velocity to +/-MAX_VEL.
    function automatic logic signed [DATA_W-1:0] clamp_vel(
        input logic signed [DATA_W-1:0] v
    );
        if (v > VEL_MAX)
            return VEL_MAX;
        else if (v < VEL_MIN)
            return VEL_MIN;
        else
            return v;
    endfunction

    // Sign-extend a velocity to position width so it adds in sub-pixel units.
    function automatic logic signed [POS_W-1:0] sext_vel(
        input logic signed [DATA_W-1:0] v
    );
        return {{FRAC_BITS{v[DATA_W-1]}}, v};
    endfunction

`ifdef BALL_FRICTION_EN
    // Move a velocity component one unit toward zero. Zero stays zero.
    function automatic logic signed [DATA_W-1:0] decay_vel(
        input logic signed [DATA_W-1:0] v
    );
        if (v > VEL_ZERO)
            return v - VEL_ONE;
        else if (v < VEL_ZERO)
            return v + VEL_ONE;
        else
            return v;
    endfunction
`endif

    state_t                     state;
    logic                       moving_r;
    logic                       coll_gate;
    logic signed [DATA_W-1:0]   vel_x_p0;
    logic signed [DATA_W-1:0]   vel_y_p0;
    logic signed [POS_W-1:0]    pos_x_p0;
    logic signed [POS_W-1:0]    pos_y_p0;
    logic signed [DATA_W-1:0]   top_left_x_p1;
    logic signed [DATA_W-1:0]   top_left_y_p1;
`ifdef BALL_FRICTION_EN
    logic [CNT_W-1:0]           friction_cnt;
    logic                       friction_due;
`endif

    logic                       in_motion;
    logic                       frame_step;
    logic                       coll_accept;
    logic                       stop;
    logic signed [DATA_W-1:0]   step_vel_x;
    logic signed [DATA_W-1:0]   step_vel_y;
    logic signed [DATA_W-1:0]   next_vel_x;
    logic signed [DATA_W-1:0]   next_vel_y;

    // Next-velocity selection. An accepted collision overrides any friction
    // decay in the same cycle, because the corrected velocity comes from a
    // bounce that belongs to the new frame.
    always_comb begin
        in_motion   = (state == MOVING);
        frame_step  = in_motion && bus.startOfFrame;
        coll_accept = in_motion && bus.collisionOccurred && !coll_gate;
        step_vel_x  = vel_x_p0;
        step_vel_y  = vel_y_p0;
`ifdef BALL_FRICTION_EN
        friction_due = frame_step && (friction_cnt == CNT_LAST);
        if (friction_due) begin
            step_vel_x = decay_vel(vel_x_p0);
            step_vel_y = decay_vel(vel_y_p0);
        end
`endif
        next_vel_x = coll_accept ? clamp_vel(bus.collVelX) : step_vel_x;
        next_vel_y = coll_accept ? clamp_vel(bus.collVelY) : step_vel_y;
        stop       = frame_step && (next_vel_x == VEL_ZERO) && (next_vel_y == VEL_ZERO);
    end

    // Stage p0: motion state, velocity and sub-pixel position.
    // Stage p1: integer top-left, one cycle behind the position.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            moving_r      <= 1'b0;
            coll_gate     <= 1'b0;
            vel_x_p0      <= VEL_ZERO;
            vel_y_p0      <= VEL_ZERO;
            pos_x_p0      <= POS_INIT_X;
            pos_y_p0      <= POS_INIT_Y;
            top_left_x_p1 <= TL_INIT_X;
            top_left_y_p1 <= TL_INIT_Y;
`ifdef BALL_FRICTION_EN
            friction_cnt  <= '0;
`endif
        end else begin
            // The slice is the arithmetic right shift by FRAC_BITS, truncated to
            // output width.
            top_left_x_p1 <= pos_x_p0[FRAC_BITS +: DATA_W];
            top_left_y_p1 <= pos_y_p0[FRAC_BITS +: DATA_W];

            unique case (state)
                IDLE: begin
                    // A frame pulse in the same cycle does not move the ball.
                    // Motion starts with the next frame.
                    if (bus.shotValid) begin
                        vel_x_p0  <= clamp_vel(bus.shotVelX);
                        vel_y_p0  <= clamp_vel(bus.shotVelY);
                        coll_gate <= 1'b0;
                        state     <= MOVING;
                        moving_r  <= 1'b1;
                    end
                end

                MOVING: begin
                    vel_x_p0 <= next_vel_x;
                    vel_y_p0 <= next_vel_y;

                    if (frame_step) begin
                        // Position always advances with the velocity that was in
                        // force during the frame just ended.
                        pos_x_p0 <= pos_x_p0 + sext_vel(vel_x_p0);
                        pos_y_p0 <= pos_y_p0 + sext_vel(vel_y_p0);
`ifdef BALL_FRICTION_EN
                        friction_cnt <= friction_due ? '0 : friction_cnt + 1'b1;
`endif
                    end

                    // One bounce per frame. If a bounce coincides with the frame
                    // pulse, it is charged to the new frame.
                    if (coll_accept)
                        coll_gate <= 1'b1;
                    else if (frame_step)
                        coll_gate <= 1'b0;

                    if (stop) begin
                        state    <= IDLE;
                        moving_r <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    moving_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.topLeftX = top_left_x_p1;
    assign bus.topLeftY = top_left_y_p1;
    assign bus.ballVelX = vel_x_p0;
    assign bus.ballVelY = vel_y_p0;
    assign bus.moving   = moving_r;

endmodule
